// File: rtl/song_sequencer.sv
// Loadable song-memory note sequencer for the piano auto-play path.
// Steps through {note, duration} entries on an external beat strobe.
module song_sequencer #(
  parameter int SONG_LEN = 64,
  parameter int DUR_W    = 3,
  localparam int ADDR_W  = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              BEAT_TICK,
  input  logic              START,
  input  logic              STOP,
  input  logic              PAUSE,
  input  logic              LOOP,
  input  logic              ARTIC,
  input  logic              WR_EN,
  input  logic [ADDR_W-1:0] WR_ADDR,
  input  logic [3:0]        WR_NOTE,
  input  logic [DUR_W-1:0]  WR_DUR,
  output logic [3:0]        NOTE,
  output logic [7:0]        LED,
  output logic [ADDR_W-1:0] POS,
  output logic              PLAYING,
  output logic              DONE
);

  typedef enum logic [1:0] {IDLE, PLAY, GAP, PAUSED} state_t;

  localparam logic [3:0] REST = 4'd8;
  localparam logic [3:0] EOS  = 4'd15;

  state_t            state;
  logic              ret_gap;
  logic [DUR_W-1:0]  cnt;
  logic [3:0]        mem_note [SONG_LEN];
  logic [DUR_W-1:0]  mem_dur  [SONG_LEN];

  logic              at_last;
  logic [ADDR_W-1:0] next_pos;
  logic              song_end;
  logic              first_end;

  function automatic logic [7:0] led_of(input logic [3:0] n);
    if (n < 4'd8)
      led_of = 8'h80 >> n;
    else if (n == REST)
      led_of = 8'h00;
    else
      led_of = 8'hFF;
  endfunction

  // The successor index is forced to 0 on the last slot so it never leaves the array.
  assign at_last   = (POS == ADDR_W'(SONG_LEN - 1));
  assign next_pos  = at_last ? '0 : POS + ADDR_W'(1);
  assign song_end  = at_last || (mem_note[next_pos] == EOS);
  assign first_end = (mem_note[0] == EOS);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state   <= IDLE;
      ret_gap <= 1'b0;
      cnt     <= '0;
      POS     <= '0;
      NOTE    <= REST;
      LED     <= 8'h00;
      PLAYING <= 1'b0;
      DONE    <= 1'b0;
      for (int i = 0; i < SONG_LEN; i++) begin
        mem_note[i] <= EOS;
        mem_dur[i]  <= '0;
      end
    end else begin
      DONE <= 1'b0;

      if (WR_EN && state == IDLE) begin
        mem_note[WR_ADDR] <= WR_NOTE;
        mem_dur[WR_ADDR]  <= WR_DUR;
      end

      if (STOP) begin
        state   <= IDLE;
        POS     <= '0;
        cnt     <= '0;
        NOTE    <= REST;
        LED     <= 8'h00;
        PLAYING <= 1'b0;
      end else if (START) begin
        POS <= '0;
        cnt <= '0;
        if (first_end) begin
          state   <= IDLE;
          NOTE    <= REST;
          LED     <= 8'h00;
          PLAYING <= 1'b0;
          DONE    <= 1'b1;
        end else begin
          state   <= PLAY;
          NOTE    <= mem_note[0];
          LED     <= led_of(mem_note[0]);
          PLAYING <= 1'b1;
        end
      end else begin
        case (state)
          PLAY, GAP: begin
            if (PAUSE) begin
              state   <= PAUSED;
              ret_gap <= (state == GAP);
              NOTE    <= REST;
              LED     <= 8'h00;
            end else if (BEAT_TICK) begin
              if (state == PLAY && cnt != mem_dur[POS]) begin
                cnt <= cnt + DUR_W'(1);
              end else if (state == PLAY && ARTIC) begin
                state <= GAP;
                NOTE  <= REST;
                LED   <= 8'h00;
              end else if (!song_end) begin
                state <= PLAY;
                POS   <= next_pos;
                cnt   <= '0;
                NOTE  <= mem_note[next_pos];
                LED   <= led_of(mem_note[next_pos]);
              end else if (LOOP && !first_end) begin
                state <= PLAY;
                POS   <= '0;
                cnt   <= '0;
                NOTE  <= mem_note[0];
                LED   <= led_of(mem_note[0]);
              end else begin
                state   <= IDLE;
                POS     <= '0;
                cnt     <= '0;
                NOTE    <= REST;
                LED     <= 8'h00;
                PLAYING <= 1'b0;
                DONE    <= 1'b1;
              end
            end
          end
          PAUSED: begin
            // Counter is left untouched so the entry resumes with its remaining beats.
            if (!PAUSE) begin
              if (ret_gap) begin
                state <= GAP;
              end else begin
                state <= PLAY;
                NOTE  <= mem_note[POS];
                LED   <= led_of(mem_note[POS]);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// Directed-vector bench for song_sequencer with hand-computed expectations.
module tb_song_sequencer;

  localparam int SONG_LEN = 64;
  localparam int DUR_W    = 3;
  localparam int ADDR_W   = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              beat_tick, start, stop, pause, loop_en, artic, wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [3:0]        wr_note;
  logic [DUR_W-1:0]  wr_dur;
  logic [3:0]        note;
  logic [7:0]        led;
  logic [ADDR_W-1:0] pos;
  logic              playing, done;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  song_sequencer #(.SONG_LEN(SONG_LEN), .DUR_W(DUR_W)) dut (
    .CLK(clk), .RESET(rst_n), .BEAT_TICK(beat_tick), .START(start), .STOP(stop),
    .PAUSE(pause), .LOOP(loop_en), .ARTIC(artic), .WR_EN(wr_en), .WR_ADDR(wr_addr),
    .WR_NOTE(wr_note), .WR_DUR(wr_dur), .NOTE(note), .LED(led), .POS(pos),
    .PLAYING(playing), .DONE(done)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int n, input int d);
    wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_note = 4'(n); wr_dur = DUR_W'(d);
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; cyc(); stop = 1'b0;
  endtask

  task automatic beat();
    beat_tick = 1'b1; cyc(); beat_tick = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, ".note"}, 32'(note), 32'd8);
    check_val({tag, ".led"}, 32'(led), 32'h00);
    check_val({tag, ".pos"}, 32'(pos), 32'd0);
    check_val({tag, ".playing"}, 32'(playing), 32'd0);
  endtask

  initial begin
    int exp_note_a[4];
    int exp_pos_a[4];
    int exp_note_b[7];

    exp_note_a = '{5, 5, 5, 3};
    exp_pos_a  = '{0, 1, 1, 2};
    exp_note_b = '{5, 8, 5, 5, 8, 3, 8};

    rst_n = 1'b0; beat_tick = 0; start = 0; stop = 0; pause = 0;
    loop_en = 0; artic = 0; wr_en = 0; wr_addr = '0; wr_note = '0; wr_dur = '0;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    check_val("reset.done", 32'(done), 32'd0);
    rst_n = 1'b1;
    cyc();

    // Empty song: START ends immediately.
    pulse_start();
    check_val("empty.done", 32'(done), 32'd1);
    check_idle("empty");
    cyc();
    check_val("empty.done_drop", 32'(done), 32'd0);

    wr(0, 5, 0); wr(1, 5, 1); wr(2, 3, 0); wr(3, 15, 0);

    // Plain playback; the tick coinciding with START is discarded.
    start = 1'b1; beat_tick = 1'b1; cyc(); start = 1'b0; beat_tick = 1'b0;
    check_val("plain.s.note", 32'(note), 32'(exp_note_a[0]));
    check_val("plain.s.led", 32'(led), 32'h04);
    check_val("plain.s.pos", 32'(pos), 32'(exp_pos_a[0]));
    check_val("plain.s.playing", 32'(playing), 32'd1);
    for (int i = 1; i < 4; i++) begin
      beat();
      check_val($sformatf("plain.t%0d.note", i), 32'(note), 32'(exp_note_a[i]));
      check_val($sformatf("plain.t%0d.pos", i), 32'(pos), 32'(exp_pos_a[i]));
      check_val($sformatf("plain.t%0d.done", i), 32'(done), 32'd0);
    end
    check_val("plain.t3.led", 32'(led), 32'h10);
    beat();
    check_val("plain.t4.done", 32'(done), 32'd1);
    check_idle("plain.t4");
    cyc();
    check_val("plain.done_drop", 32'(done), 32'd0);

    // Articulated playback: a rest after every entry.
    artic = 1'b1;
    pulse_start();
    check_val("artic.s.note", 32'(note), 32'(exp_note_b[0]));
    for (int i = 1; i < 7; i++) begin
      beat();
      check_val($sformatf("artic.t%0d.note", i), 32'(note), 32'(exp_note_b[i]));
      check_val($sformatf("artic.t%0d.done", i), 32'(done), 32'd0);
    end
    check_val("artic.t6.playing", 32'(playing), 32'd1);
    beat();
    check_val("artic.t7.done", 32'(done), 32'd1);
    check_idle("artic.t7");
    artic = 1'b0;

    // Looping: wraps to entry 0, never pulses DONE.
    loop_en = 1'b1;
    pulse_start();
    for (int i = 1; i <= 10; i++) begin
      beat();
      check_val($sformatf("loop.t%0d.done", i), 32'(done), 32'd0);
      if (i == 4) begin
        check_val("loop.t4.pos", 32'(pos), 32'd0);
        check_val("loop.t4.note", 32'(note), 32'd5);
      end
    end
    check_val("loop.t10.pos", 32'(pos), 32'd1);
    pulse_stop();
    check_idle("stop");
    check_val("stop.done", 32'(done), 32'd0);
    loop_en = 1'b0;

    // Pause in the middle of entry 1 with ticks that must be ignored.
    pulse_start();
    beat();
    check_val("pause.pre.pos", 32'(pos), 32'd1);
    pause = 1'b1;
    for (int i = 0; i < 20; i++) begin
      beat_tick = (i == 5 || i == 10 || i == 15);
      cyc();
      if (i == 0 || i == 19) begin
        check_val($sformatf("pause.c%0d.note", i), 32'(note), 32'd8);
        check_val($sformatf("pause.c%0d.led", i), 32'(led), 32'h00);
        check_val($sformatf("pause.c%0d.pos", i), 32'(pos), 32'd1);
        check_val($sformatf("pause.c%0d.playing", i), 32'(playing), 32'd1);
      end
    end
    beat_tick = 1'b0;
    pause = 1'b0;
    cyc();
    check_val("resume.note", 32'(note), 32'd5);
    check_val("resume.pos", 32'(pos), 32'd1);
    beat();
    check_val("resume.t1.pos", 32'(pos), 32'd1);
    beat();
    check_val("resume.t2.pos", 32'(pos), 32'd2);
    check_val("resume.t2.note", 32'(note), 32'd3);
    beat();
    check_val("resume.t3.done", 32'(done), 32'd1);

    // Write while playing must be dropped.
    pulse_start();
    wr(0, 2, 0);
    pulse_stop();
    pulse_start();
    check_val("wrplay.note", 32'(note), 32'd5);

    // STOP and START together end in IDLE.
    start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
    check_idle("stopstart");
    check_val("stopstart.done", 32'(done), 32'd0);

    // Unpitched code lights every LED; then async reset mid-song.
    wr(0, 10, 0);
    pulse_start();
    check_val("unp.note", 32'(note), 32'd10);
    check_val("unp.led", 32'(led), 32'hFF);
    beat();
    check_val("unp.t1.note", 32'(note), 32'd5);
    #3;
    rst_n = 1'b0;
    #1;
    check_idle("areset");
    check_val("areset.done", 32'(done), 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    pulse_start();
    check_val("areset.memclr.done", 32'(done), 32'd1);
    check_val("areset.memclr.playing", 32'(playing), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/song_sequencer.md
# song_sequencer

Programmable, parametrised note sequencer for the FPGA piano's auto-play path. It replaces fixed per-song note tables with a loadable song memory: each entry holds a note code and a duration in beats. Playback steps through the entries on an external beat strobe, with optional rest-gap articulation, looping, pause and stop. Its NOTE output drives the tone generator and its LED output drives the board LEDs.

## Interface
Parameters:
- SONG_LEN, 64: number of song-memory entries; ADDR_W = clog2(SONG_LEN), minimum 1.
- DUR_W, 3: duration field width. A stored value d plays for d+1 beats.

Ports:
- CLK  in  1: system clock; all state changes on its rising edge.
- RESET  in  1: asynchronous, active-low reset.
- BEAT_TICK  in  1: one-CLK-cycle strobe, one per beat.
- START  in  1: one-cycle pulse; begin playback at entry 0.
- STOP  in  1: one-cycle pulse; abort playback.
- PAUSE  in  1: level; freeze playback while high.
- LOOP  in  1: level, sampled at end of song; 1 = wrap to entry 0.
- ARTIC  in  1: level; 1 = insert a one-beat rest after every note entry.
- WR_EN  in  1: song-memory write strobe.
- WR_ADDR  in  ADDR_W: write address.
- WR_NOTE  in  4: note code to store.
- WR_DUR  in  DUR_W: duration code to store.
- NOTE  out  4: current note code; 8 = rest/none.
- LED  out  8: one-hot note display.
- POS  out  ADDR_W: index of the entry currently playing.
- PLAYING  out  1: high in PLAY, GAP and PAUSED.
- DONE  out  1: one-cycle pulse on non-looping end of song.

## Operation
- Note codes:
  - 0 through 7 are C5, B, A, G, F, E, D, C4.
  - 8 is a rest.
  - 15 is the end-of-song marker.
  - 9 through 14 are played as held, unpitched entries.
- LED mapping:
  - Code k in 0..7 sets LED bit (7−k) only.
  - Code 8 gives 8'h00.
  - Codes 9 through 15 give 8'hFF.
  - LED is registered together with NOTE.
- Memory:
  - SONG_LEN×(4+DUR_W) register array with combinational read.
  - Reset loads every entry with {15, 0}.
  - Writes are accepted only in IDLE. A write in any other state is dropped.
- States:
  - IDLE: NOTE=8.
  - PLAY: NOTE = mem[POS].note.
  - GAP: NOTE=8.
  - PAUSED: NOTE=8; holds a 1-bit return flag (PLAY or GAP).
- Beat counter: width DUR_W, cleared on every entry into PLAY.
- Input priority, per cycle: STOP > START > PAUSE > BEAT_TICK.
- STOP: any state → IDLE, POS=0, DONE stays 0.
- START from any state, including mid-song: POS=0, counter=0.
  - If mem[0].note is 15: stay/go IDLE and pulse DONE.
  - Otherwise go to PLAY.
- PAUSE high in PLAY or GAP: go to PAUSED and save the return state. Counter and POS are frozen and ticks are ignored.
- PAUSE low in PAUSED: return to the saved state with the counter unchanged.
- PLAY with BEAT_TICK and counter < dur: counter+1.
- PLAY with BEAT_TICK and counter == dur:
  - If ARTIC=1: go to GAP.
  - If ARTIC=0: advance.
- GAP with BEAT_TICK: advance.
- Advance:
  - next = POS+1.
  - If POS == SONG_LEN−1, or mem[next].note is 15, it is the end of song:
    - If LOOP=1: POS=0 and go to PLAY. If mem[0].note is 15, treat it as non-looping instead.
    - If LOOP=0: go to IDLE, POS=0, DONE=1 for one cycle.
  - Otherwise: POS=next, counter=0, go to PLAY.
- Reset (RESET low, asynchronous):
  - State IDLE, NOTE=8, LED=8'h00, POS=0, PLAYING=0, DONE=0, counter=0.
  - Memory is cleared to end markers.
  - Reset mid-playback aborts with no DONE.

## Timing
- START sampled at edge n: NOTE, LED, POS and PLAYING reflect entry 0 after edge n. Latency is 1 cycle.
- An entry with duration code d occupies d+1 BEAT_TICKs.
  - With ARTIC=1 it occupies d+2 ticks, the last of which is a rest.
- Note changes take effect on the edge that samples the terminating BEAT_TICK.
- DONE is asserted for exactly the one cycle after the final terminating tick. PLAYING falls on the same edge.
- START and BEAT_TICK together: the tick is discarded.
- STOP and START together: the result is IDLE.
- A write to an address during IDLE is visible to a START on the next cycle.
- BEAT_TICK held high for k cycles counts as k ticks. The source must pulse it.

## Test plan
- Reset then START with no song loaded → DONE pulses 1 cycle after START; NOTE=8; PLAYING stays 0.
- Load {5,0},{5,1},{3,0},{15,0}; ARTIC=0, LOOP=0; START, then 4 ticks → NOTE sequence 5,5,5,3; LED 8'h04 then 8'h10; DONE on the 4th tick; POS back to 0.
- Same song with ARTIC=1 → NOTE sequence 5,8,5,5,8,3,8; DONE on the 7th tick.
- Same song with LOOP=1; run 10 ticks → after the 4th tick POS=0 and NOTE=5 again; DONE never asserted.
- PAUSE high for 20 cycles with 3 ticks in the middle of entry 1 → NOTE=8 while paused; resume on entry 1 with the remaining beat count unchanged.
- Write during PLAY to address 0 → ignored, verified by replay. STOP mid-song → IDLE next cycle, DONE=0. Async RESET mid-song → all outputs at reset values immediately.
